// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writable program memory with byte-serial loader.
// Assembles big-endian instruction words from strobed bytes.
module prog_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 35,
  parameter int NBYTES = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic              Sample,
  input  logic [7:0]        Din,
  input  logic [ADDR_W-1:0] IP,
  output logic [WORD_W-1:0] Instr,
  output logic [ADDR_W-1:0] Addr,
  output logic [2:0]        ByteIdx,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam int TOP_W = WORD_W - 8 * (NBYTES - 1);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] LAST = 3'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FULL
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr, addr_n;
  logic [2:0]        idx, idx_n;
  logic [WORD_W-1:0] word, word_n;
  logic              err, err_n;
  logic              s1, s2, s_prev;
  logic              load_q;
  logic              pulse;
  logic              load_rise;

  logic [WORD_W-1:0] mem [DEPTH];

  assign pulse     = s2 & ~s_prev;
  assign load_rise = Load & ~load_q;

  // State, datapath registers and Sample synchronizer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      addr   <= '0;
      idx    <= '0;
      word   <= '0;
      err    <= 1'b0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      idx    <= idx_n;
      word   <= word_n;
      err    <= err_n;
      s1     <= Sample;
      s2     <= s1;
      s_prev <= s2;
      load_q <= Load;
    end
  end

  // Next-state and datapath update; a new first byte's
  // error outranks the clear from a simultaneous Load rise.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    idx_n   = idx;
    word_n  = word;
    err_n   = err;
    if (load_rise) err_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (Load && pulse) begin
          word_n  = WORD_W'(Din[TOP_W-1:0]);
          idx_n   = 3'd1;
          state_n = COLLECT;
          if (Din[7:TOP_W] != '0) err_n = 1'b1;
        end
      end
      COLLECT: begin
        if (!Load) begin
          idx_n   = '0;
          state_n = IDLE;
        end else if (pulse) begin
          word_n = {word[WORD_W-9:0], Din};
          if (idx == LAST) begin
            idx_n   = '0;
            state_n = WRITE;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      WRITE: begin
        if (addr == ADDR_MAX) begin
          state_n = FULL;
        end else begin
          addr_n  = addr + ADDR_W'(1);
          state_n = IDLE;
        end
      end
      FULL: begin
        if (!Load) begin
          addr_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory write port; reset in the WRITE cycle drops the word.
  always_ff @(posedge Clock) begin
    if (!Reset && state == WRITE) mem[addr] <= word;
  end

  assign Instr   = mem[IP];
  assign Addr    = addr;
  assign ByteIdx = idx;
  assign Busy    = (state == COLLECT) || (state == WRITE);
  assign Done    = (state == FULL);
  assign Err     = err;

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed self-checking bench
// for the program memory loader.
module tb_prog_mem_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Load;
  logic        Sample;
  logic [7:0]  Din;
  logic [7:0]  IP;
  logic [34:0] Instr;
  logic [7:0]  Addr;
  logic [2:0]  ByteIdx;
  logic        Busy;
  logic        Done;
  logic        Err;

  int total = 0;
  int bad = 0;

  always #5 Clock = ~Clock;

  prog_mem_loader dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Load   (Load),
    .Sample (Sample),
    .Din    (Din),
    .IP     (IP),
    .Instr  (Instr),
    .Addr   (Addr),
    .ByteIdx(ByteIdx),
    .Busy   (Busy),
    .Done   (Done),
    .Err    (Err)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag,
                         input logic [7:0] a,
                         input logic [34:0] exp);
    IP = a;
    #1;
    chk(tag, 64'(Instr), 64'(exp));
  endtask

  task automatic send_byte(input logic [7:0] b);
    Din = b;
    Sample = 1'b1;
    repeat (3) tick();
    Sample = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_word(input logic [34:0] w);
    send_byte({5'b0, w[34:32]});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  initial begin
    Reset = 1'b1;
    Load = 1'b0;
    Sample = 1'b0;
    Din = 8'h00;
    IP = 8'h00;
    tick();
    chk("rst_addr", 64'(Addr), 64'd0);
    chk("rst_idx", 64'(ByteIdx), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_err", 64'(Err), 64'd0);
    tick();
    Reset = 1'b0;
    tick();

    // fill all 256 words, word n = n
    Load = 1'b1;
    tick();
    for (int n = 0; n < 256; n++) begin
      send_word(35'(n));
      if (n == 0) chk("wrap_addr1", 64'(Addr), 64'd1);
    end
    chk("full_done", 64'(Done), 64'd1);
    chk("full_addr", 64'(Addr), 64'd255);
    chk("full_busy", 64'(Busy), 64'd0);
    chk_mem("full_m255", 8'd255, 35'd255);
    chk_mem("full_m128", 8'd128, 35'd128);
    send_byte(8'h07);
    chk("b257_done", 64'(Done), 64'd1);
    chk("b257_addr", 64'(Addr), 64'd255);
    chk("b257_idx", 64'(ByteIdx), 64'd0);
    chk_mem("b257_m255", 8'd255, 35'd255);
    chk_mem("b257_m0", 8'd0, 35'd0);
    Load = 1'b0;
    tick();
    chk("unld_done", 64'(Done), 64'd0);
    chk("unld_addr", 64'(Addr), 64'd0);

    // single word at 0 with WRITE-cycle observation
    Load = 1'b1;
    tick();
    send_byte(8'h05);
    chk("sw_busy1", 64'(Busy), 64'd1);
    chk("sw_idx1", 64'(ByteIdx), 64'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    chk("sw_idx4", 64'(ByteIdx), 64'd4);
    IP = 8'd0;
    Din = 8'h78;
    Sample = 1'b1;
    tick();
    tick();
    chk("sw_busy_pre", 64'(Busy), 64'd1);
    chk("sw_idx_pre", 64'(ByteIdx), 64'd4);
    tick();
    chk("wr_busy", 64'(Busy), 64'd1);
    chk("wr_idx", 64'(ByteIdx), 64'd0);
    chk("wr_addr", 64'(Addr), 64'd0);
    chk("wr_old", 64'(Instr), 64'd0);
    tick();
    chk("post_busy", 64'(Busy), 64'd0);
    chk("post_addr", 64'(Addr), 64'd1);
    chk("post_instr", 64'(Instr), 64'h5_1234_5678);
    Sample = 1'b0;
    repeat (3) tick();

    // error flag
    send_byte(8'hFD);
    chk("err_set", 64'(Err), 64'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk_mem("err_word", 8'd1, 35'h5_1122_3344);
    chk("err_addr", 64'(Addr), 64'd2);
    send_word(35'h1_0000_00AA);
    chk("err_sticky", 64'(Err), 64'd1);
    chk_mem("err_w2", 8'd2, 35'h1_0000_00AA);
    Load = 1'b0;
    tick();
    chk("err_lowld", 64'(Err), 64'd1);
    Load = 1'b1;
    tick();
    chk("err_clr", 64'(Err), 64'd0);
    chk("err_addr3", 64'(Addr), 64'd3);

    // abort after 3 bytes
    send_byte(8'h07);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("ab_idx3", 64'(ByteIdx), 64'd3);
    Load = 1'b0;
    tick();
    chk("ab_idx", 64'(ByteIdx), 64'd0);
    chk("ab_busy", 64'(Busy), 64'd0);
    chk("ab_addr", 64'(Addr), 64'd3);
    chk_mem("ab_mem", 8'd3, 35'd3);
    Load = 1'b1;
    tick();
    send_word(35'h2_DEAD_BEEF);
    chk_mem("ab_redo", 8'd3, 35'h2_DEAD_BEEF);
    chk("ab_addr4", 64'(Addr), 64'd4);

    // pulses with Load low are ignored
    Load = 1'b0;
    tick();
    send_byte(8'h03);
    chk("nold_idx", 64'(ByteIdx), 64'd0);
    chk("nold_busy", 64'(Busy), 64'd0);
    chk("nold_addr", 64'(Addr), 64'd4);

    // Sample held high 10 cycles = one byte, 2 edges late
    Load = 1'b1;
    tick();
    Din = 8'h01;
    Sample = 1'b1;
    tick();
    chk("hold_e0", 64'(ByteIdx), 64'd0);
    tick();
    chk("hold_e1", 64'(ByteIdx), 64'd0);
    tick();
    chk("hold_e2", 64'(ByteIdx), 64'd1);
    repeat (7) tick();
    Sample = 1'b0;
    repeat (3) tick();
    chk("hold_one", 64'(ByteIdx), 64'd1);
    Load = 1'b0;
    tick();
    chk("hold_ab", 64'(ByteIdx), 64'd0);
    Load = 1'b1;
    tick();

    // reset during the WRITE cycle
    send_byte(8'hF8);
    chk("rw_err", 64'(Err), 64'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    Din = 8'h44;
    Sample = 1'b1;
    repeat (3) tick();
    chk("rw_inwr", 64'(Busy), 64'd1);
    chk("rw_inidx", 64'(ByteIdx), 64'd0);
    Reset = 1'b1;
    Sample = 1'b0;
    tick();
    Reset = 1'b0;
    chk("rw_addr", 64'(Addr), 64'd0);
    chk("rw_idx", 64'(ByteIdx), 64'd0);
    chk("rw_busy", 64'(Busy), 64'd0);
    chk("rw_err0", 64'(Err), 64'd0);
    chk_mem("rw_m4", 8'd4, 35'd4);
    chk_mem("rw_m0", 8'd0, 35'h5_1234_5678);
    chk_mem("rw_m1", 8'd1, 35'h5_1122_3344);
    chk_mem("rw_m3", 8'd3, 35'h2_DEAD_BEEF);
    repeat (3) tick();
    chk("rw_idle", 64'(Busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
